// File: rtl/dac_corr_pkg.sv
// DAC correction engine shared types and default widths.
// Derived widths here follow the default parameter set.
package dac_corr_pkg;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_IN_W = 16;
  localparam int DEF_OUT_W = 12;
  localparam int DEF_GAIN_W = 18;
  localparam int DEF_GAIN_FRAC = 16;
  localparam int DEF_OFS_W = 10;

  localparam int SUM_W = DEF_IN_W + 1;
  localparam int PROD_W = DEF_IN_W + DEF_GAIN_W + 2;
  localparam int OUT_MAX = (1 << DEF_OUT_W) - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/dac_corr_sat.sv
// Arithmetic shift of the gain product and clamp
// to the unsigned DAC code range.
module dac_corr_sat
  import dac_corr_pkg::*;
#(
  parameter int P_W = PROD_W,
  parameter int FRAC = DEF_GAIN_FRAC,
  parameter int O_W = DEF_OUT_W
) (
  input  logic signed [P_W-1:0] prod,
  output logic [O_W-1:0]        code,
  output logic                  sat
);

  localparam logic signed [P_W-1:0] MAXV =
    P_W'((1 << O_W) - 1);

  logic signed [P_W-1:0] res;

  always_comb begin
    res = prod >>> FRAC;
    code = res[O_W-1:0];
    sat = 1'b0;
    unique case (1'b1)
      res[P_W-1]: begin
        code = '0;
        sat = 1'b1;
      end
      (res > MAXV): begin
        code = '1;
        sat = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dac_corr_pipe.sv
// Per-channel DAC offset/gain correction: one frame
// in, channels issued serially through a shared pipe.
module dac_corr_pipe
  import dac_corr_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int OFS_W = DEF_OFS_W,
  parameter logic [GAIN_W-1:0] GAIN_RST = 18'h10000,
  parameter logic [OFS_W-1:0] OFS_RST = '0,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [NUM_CH-1:0]       out_sat,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [GAIN_W-1:0]       cfg_gain,
  input  logic [OFS_W-1:0]        cfg_ofs
);

  localparam int SW = IN_W + 1;
  localparam int PW = IN_W + GAIN_W + 2;
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

  state_e state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic iss_q, iss_d;

  logic [IN_W-1:0] buf_q [NUM_CH];
  logic [IN_W-1:0] buf_d [NUM_CH];
  logic [GAIN_W-1:0] gain_q [NUM_CH];
  logic [GAIN_W-1:0] gain_d [NUM_CH];
  logic [OFS_W-1:0] ofs_q [NUM_CH];
  logic [OFS_W-1:0] ofs_d [NUM_CH];

  logic s1_v_q, s1_v_d;
  logic [CH_W-1:0] s1_ch_q, s1_ch_d;
  logic signed [SW-1:0] s1_sum_q, s1_sum_d;
  logic [GAIN_W-1:0] s1_gain_q, s1_gain_d;

  logic s2_v_q, s2_v_d;
  logic [CH_W-1:0] s2_ch_q, s2_ch_d;
  logic signed [PW-1:0] s2_prod_q, s2_prod_d;

  logic [NUM_CH*OUT_W-1:0] out_data_q, out_data_d;
  logic [NUM_CH-1:0] out_sat_q, out_sat_d;

  logic signed [IN_W-1:0] smp;
  logic signed [OFS_W-1:0] ofs_s;
  logic signed [PW-1:0] mul_a, mul_b;
  logic [OUT_W-1:0] sat_code;
  logic sat_flag;
  logic cfg_ok;

  assign cfg_ok = cfg_we && (32'(cfg_ch) < NUM_CH);
  assign in_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data = out_data_q;
  assign out_sat = out_sat_q;

  dac_corr_sat #(
    .P_W (PW),
    .FRAC(GAIN_FRAC),
    .O_W (OUT_W)
  ) u_sat (
    .prod(s2_prod_q),
    .code(sat_code),
    .sat (sat_flag)
  );

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    iss_d = iss_q;
    buf_d = buf_q;
    gain_d = gain_q;
    ofs_d = ofs_q;
    s1_v_d = 1'b0;
    s1_ch_d = s1_ch_q;
    s1_sum_d = s1_sum_q;
    s1_gain_d = s1_gain_q;
    s2_v_d = s1_v_q;
    s2_ch_d = s1_ch_q;
    out_data_d = out_data_q;
    out_sat_d = out_sat_q;
    smp = buf_q[idx_q];
    ofs_s = ofs_q[idx_q];
    mul_a = PW'(s1_sum_q);
    mul_b = PW'({1'b0, s1_gain_q});
    s2_prod_d = mul_a * mul_b;

    // Register reads below see pre-write values.
    if (cfg_ok) begin
      gain_d[cfg_ch] = cfg_gain;
      ofs_d[cfg_ch] = cfg_ofs;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < NUM_CH; k++) begin
            buf_d[k] = in_data[k*IN_W +: IN_W];
          end
          idx_d = '0;
          iss_d = 1'b1;
          out_sat_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (iss_q) begin
          s1_v_d = 1'b1;
          s1_ch_d = idx_q;
          s1_sum_d = SW'(smp) + SW'(ofs_s);
          s1_gain_d = gain_q[idx_q];
          if (idx_q == LAST) iss_d = 1'b0;
          else idx_d = idx_q + 1'b1;
        end
        if (s2_v_q && s2_ch_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (s2_v_q) begin
      out_data_d[s2_ch_q*OUT_W +: OUT_W] = sat_code;
      out_sat_d[s2_ch_q] = sat_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      iss_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        buf_q[k] <= '0;
        gain_q[k] <= GAIN_RST;
        ofs_q[k] <= OFS_RST;
      end
      s1_v_q <= 1'b0;
      s1_ch_q <= '0;
      s1_sum_q <= '0;
      s1_gain_q <= '0;
      s2_v_q <= 1'b0;
      s2_ch_q <= '0;
      s2_prod_q <= '0;
      out_data_q <= '0;
      out_sat_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      iss_q <= iss_d;
      buf_q <= buf_d;
      gain_q <= gain_d;
      ofs_q <= ofs_d;
      s1_v_q <= s1_v_d;
      s1_ch_q <= s1_ch_d;
      s1_sum_q <= s1_sum_d;
      s1_gain_q <= s1_gain_d;
      s2_v_q <= s2_v_d;
      s2_ch_q <= s2_ch_d;
      s2_prod_q <= s2_prod_d;
      out_data_q <= out_data_d;
      out_sat_q <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_dac_corr_pipe.sv
// Self-checking bench for dac_corr_pipe against an
// arithmetic reference of the correction rules.
module tb_dac_corr_pipe;

  localparam int NUM_CH = 2;
  localparam int IN_W = 16;
  localparam int OUT_W = 12;
  localparam int GAIN_W = 18;
  localparam int OFS_W = 10;
  localparam int UNITY = 65536;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic cfg_we = 1'b0;
  logic in_ready, out_valid;
  logic [NUM_CH*IN_W-1:0] in_data = '0;
  logic [NUM_CH*OUT_W-1:0] out_data;
  logic [NUM_CH-1:0] out_sat;
  logic [0:0] cfg_ch = '0;
  logic [GAIN_W-1:0] cfg_gain = '0;
  logic [OFS_W-1:0] cfg_ofs = '0;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int mg [NUM_CH];
  int mo [NUM_CH];

  always #5 clk = ~clk;

  dac_corr_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_gain (cfg_gain),
    .cfg_ofs  (cfg_ofs)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Reference: (sample + offset) * gain / 2^16,
  // floored, then clipped to 0..4095.
  function automatic void model(input int s, input int ch,
                                output int code,
                                output bit sat);
    longint p;
    longint r;
    p = longint'(s + mo[ch]) * longint'(mg[ch]);
    r = p >>> 16;
    if (r < 0) begin
      code = 0;
      sat = 1'b1;
    end else if (r > 4095) begin
      code = 4095;
      sat = 1'b1;
    end else begin
      code = int'(r);
      sat = 1'b0;
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      mg[k] = UNITY;
      mo[k] = 0;
    end
  endtask

  task automatic cfg(input int ch, input int g, input int o);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_ch = 1'(ch);
    cfg_gain = GAIN_W'(g);
    cfg_ofs = OFS_W'(o);
    @(negedge clk);
    cfg_we = 1'b0;
    mg[ch] = g;
    mo[ch] = o;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
  endtask

  task automatic release_out();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  task automatic send_frame(input int a, input int b,
                            input int hold);
    int e0, e1, n;
    bit s0, s1;
    logic [NUM_CH*OUT_W-1:0] d;
    logic [NUM_CH-1:0] sv;
    model(a, 0, e0, s0);
    model(b, 1, e1, s1);
    @(negedge clk);
    in_data = {16'(b), 16'(a)};
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n);
    chk("latency", n, 4);
    chk("ch0_code", out_data[11:0], e0);
    chk("ch1_code", out_data[23:12], e1);
    chk("sat", out_sat, {s1, s0});
    d = out_data;
    sv = out_sat;
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 4);
      @(posedge clk);
      @(negedge clk);
      chk("hold_data", out_data, d);
      chk("hold_sat", out_sat, sv);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    release_out();
  endtask

  initial begin
    int n, a, b;
    bit seen;
    model_reset();

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send_frame(4095, 100, 0);

    cfg(0, 32'h8000, 10);
    cfg(1, UNITY, -146);
    send_frame(1000, 1146, 0);

    cfg(0, UNITY, 0);
    cfg(1, UNITY, 0);
    send_frame(-20, 5000, 0);
    send_frame(0, 4095, 0);

    send_frame(123, 456, 10);

    // Write lands on ch0's S1 edge: old gain applies.
    @(negedge clk);
    in_data = {16'd200, 16'd200};
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_ch = 1'b0;
    cfg_gain = 18'h08000;
    cfg_ofs = '0;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    wait_valid(n);
    chk("cfg_race_lat", n, 3);
    chk("cfg_race_ch0", out_data[11:0], 200);
    chk("cfg_race_ch1", out_data[23:12], 200);
    release_out();
    mg[0] = 32'h8000;
    send_frame(200, 200, 0);

    cfg(1, 32'h4000, 5);
    @(negedge clk);
    in_data = {16'd300, 16'd300};
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_valid", seen, 0);
    send_frame(300, 300, 0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1)
        cfg(int'($urandom_range(0, 1)),
            int'($urandom_range(0, 131072)),
            int'($urandom_range(0, 1023)) - 512);
      if ($urandom_range(0, 3) == 0)
        a = int'($urandom_range(0, 65535)) - 32768;
      else
        a = int'($urandom_range(0, 4500)) - 200;
      if ($urandom_range(0, 3) == 0)
        b = int'($urandom_range(0, 65535)) - 32768;
      else
        b = int'($urandom_range(0, 4500)) - 200;
      send_frame(a, b, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
